// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one {hi, lo} working register, with a start/busy/done handshake.
module muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct_3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2:0]        f3_reg;
  logic              s1_reg;
  logic              s2_reg;
  logic              special_reg;
  logic [XLEN-1:0]   spec_res_reg;
  logic [XLEN-1:0]   mag_b_reg;
  logic [XLEN-1:0]   hi_reg;
  logic [XLEN-1:0]   lo_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [XLEN-1:0]   out_reg;

  // Operand decode for the start cycle
  logic              in1_signed;
  logic              in2_signed;
  logic              s1;
  logic              s2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   spec_res;

  always_comb begin
    in1_signed = (funct_3 == 3'b001) || (funct_3 == 3'b010) ||
                 (funct_3 == 3'b100) || (funct_3 == 3'b110);
    in2_signed = (funct_3 == 3'b001) || (funct_3 == 3'b100) || (funct_3 == 3'b110);
    s1         = in1_signed & in1[XLEN-1];
    s2         = in2_signed & in2[XLEN-1];
    mag1       = s1 ? -in1 : in1;
    mag2       = s2 ? -in2 : in2;
    div_zero   = funct_3[2] && (in2 == '0);
    div_ovf    = funct_3[2] && !funct_3[0] && (in1 == MIN_VAL) && (in2 == '1);
    special    = div_zero || div_ovf;
    if (div_zero) spec_res = funct_3[1] ? in1 : '1;
    else          spec_res = funct_3[1] ? '0 : MIN_VAL;
  end

  // One datapath step per CALC cycle
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mag_b_reg} : '0);
    div_shift = {hi_reg, lo_reg[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mag_b_reg};
    div_diff  = div_shift - {1'b0, mag_b_reg};
  end

  // Sign fix-up of the magnitude result, evaluated in DONE
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result;

  always_comb begin
    prod     = {hi_reg, lo_reg};
    prod_fix = (s1_reg ^ s2_reg) ? -prod : prod;
    quo_fix  = (s1_reg ^ s2_reg) ? -lo_reg : lo_reg;
    rem_fix  = s1_reg ? -hi_reg : hi_reg;
    if (special_reg)
      result = spec_res_reg;
    else if (!f3_reg[2])
      result = (f3_reg == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      result = f3_reg[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      f3_reg       <= '0;
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      special_reg  <= 1'b0;
      spec_res_reg <= '0;
      mag_b_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      out_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              f3_reg       <= funct_3;
              s1_reg       <= s1;
              s2_reg       <= s2;
              special_reg  <= special;
              spec_res_reg <= spec_res;
              mag_b_reg    <= mag2;
              hi_reg       <= '0;
              lo_reg       <= mag1;
              cnt_reg      <= CW'(XLEN - 1);
              busy_reg     <= 1'b1;
              state_reg    <= (special && FAST_SPECIAL) ? DONE : CALC;
            end
          end
          CALC: begin
            if (f3_reg[2]) begin
              // lo holds the remaining dividend bits and collects quotient bits from the LSB
              if (div_ge) begin
                hi_reg <= div_diff[XLEN-1:0];
                lo_reg <= {lo_reg[XLEN-2:0], 1'b1};
              end else begin
                hi_reg <= div_shift[XLEN-1:0];
                lo_reg <= {lo_reg[XLEN-2:0], 1'b0};
              end
            end else begin
              hi_reg <= mul_sum[XLEN:1];
              lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
            end
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == '0) state_reg <= DONE;
          end
          DONE: begin
            out_reg   <= result;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign out  = out_reg;

endmodule
